instruction_fetch_decode: RTL and testbench

Front-end stage of the 8-bit microprocessor: fetches 32-bit instruction words from a synchronous program memory, splits them into `opcode`, three 5-bit register-file addresses and an 8-bit immediate, and issues them to the execution unit over a valid/ready handshake. Control-flow opcodes are resolved locally and never issued: `JMP` (4'hE) and `HALT` (4'hF). All other opcodes pass through to the execution unit unchanged.

---
 rtl/instruction_fetch_decode.sv | 144 ++++++++++++++
 tb/tb_instruction_fetch_decode.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_decode.sv
// Fetch/decode front end: reads 32-bit words from a 1-cycle synchronous
// program memory, resolves JMP/HALT locally and issues every other opcode to
// the execution unit over a valid/ready handshake.
// Optional feature macro: IFD_INSTR_COUNT_EN adds a 16-bit issued-instruction
// counter on port instr_count.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | quiet after reset, waits for start
// S_FETCH  | imem_en=1, read request for word at pc
// S_WAIT   | memory data arrives, latch ir, advance pc
// S_DECODE | resolve JMP/HALT, otherwise register fields for issue
// S_ISSUE  | issue_valid=1, fields held until ex_ready
// S_HALTED | halted=1, waits for start to restart at pc 0
module instruction_fetch_decode #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic            imem_en,
   output logic [PC_W-1:0] imem_addr,
   input  logic [31:0]     imem_rdata,
   output logic            issue_valid,
   input  logic            ex_ready,
   output logic [3:0]      opcode,
   output logic [4:0]      addr1,
   output logic [4:0]      addr2,
   output logic [4:0]      addr3,
   output logic [7:0]      load_number,
   output logic [PC_W-1:0] pc,
   output logic            halted
`ifdef IFD_INSTR_COUNT_EN
   ,
   output logic [15:0]     instr_count
`endif
);

   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_DECODE,
      S_ISSUE,
      S_HALTED
   } state_t;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] ir;
   logic        ir_unused;

   // ir[12:8] carries no field; only the jump target may reach into it
   assign ir_unused = ^ir[12:8];

   // Moore outputs straight from state so reset clears them asynchronously
   assign imem_en     = (state_q == S_FETCH);
   assign imem_addr   = pc;
   assign issue_valid = (state_q == S_ISSUE);
   assign halted      = (state_q == S_HALTED);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (start) state_d = S_FETCH;
         S_FETCH:  state_d = S_WAIT;
         S_WAIT:   state_d = S_DECODE;
         S_DECODE: begin
            if (ir[31:28] == OP_JMP) begin
               state_d = S_FETCH;
            end else if (ir[31:28] == OP_HALT) begin
               state_d = S_HALTED;
            end else begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE:  if (ex_ready) state_d = S_FETCH;
         S_HALTED: if (start) state_d = S_FETCH;
         default:  state_d = S_IDLE;
      endcase
   end

   // Program counter, instruction register and issued fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= '0;
         ir          <= '0;
         opcode      <= '0;
         addr1       <= '0;
         addr2       <= '0;
         addr3       <= '0;
         load_number <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_HALTED: begin
               if (start) pc <= '0;
            end
            S_WAIT: begin
               ir <= imem_rdata;
               pc <= pc + PC_W'(1);
            end
            S_DECODE: begin
               if (ir[31:28] == OP_JMP) begin
                  pc <= ir[PC_W-1:0];
               end else if (ir[31:28] != OP_HALT) begin
                  opcode      <= ir[31:28];
                  addr1       <= ir[27:23];
                  addr2       <= ir[22:18];
                  addr3       <= ir[17:13];
                  load_number <= ir[7:0];
               end
            end
            default: ;
         endcase
      end
   end

`ifdef IFD_INSTR_COUNT_EN
   // Count completed issue handshakes; an accepted start restarts the count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instr_count <= '0;
      end else if (((state_q == S_IDLE) || (state_q == S_HALTED)) && start) begin
         instr_count <= '0;
      end else if ((state_q == S_ISSUE) && ex_ready) begin
         instr_count <= instr_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instruction_fetch_decode.sv
// Directed bench for instruction_fetch_decode with an 8-bit PC and a
// behavioural 1-cycle synchronous program memory.
module tb_instruction_fetch_decode;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        imem_en;
   logic [7:0]  imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        issue_valid;
   logic        ex_ready = 1'b0;
   logic [3:0]  opcode;
   logic [4:0]  addr1;
   logic [4:0]  addr2;
   logic [4:0]  addr3;
   logic [7:0]  load_number;
   logic [7:0]  pc;
   logic        halted;
`ifdef IFD_INSTR_COUNT_EN
   logic [15:0] instr_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [31:0] mem [0:255];
   logic [7:0]  last_fetch = '0;
   int          issues = 0;
   int          ctrl_issued = 0;

   instruction_fetch_decode #(.PC_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .imem_en     (imem_en),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .issue_valid (issue_valid),
      .ex_ready    (ex_ready),
      .opcode      (opcode),
      .addr1       (addr1),
      .addr2       (addr2),
      .addr3       (addr3),
      .load_number (load_number),
      .pc          (pc),
      .halted      (halted)
`ifdef IFD_INSTR_COUNT_EN
      ,
      .instr_count (instr_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem[imem_addr];
   end

   always @(negedge clk) begin
      if (imem_en) last_fetch = imem_addr;
      if (issue_valid && ex_ready) issues = issues + 1;
      if (issue_valid && (opcode == 4'hE || opcode == 4'hF)) ctrl_issued = ctrl_issued + 1;
   end

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] word;
      logic [3:0]  op;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  a3;
      logic [7:0]  ln;
      logic [7:0]  pc_exp;
   } vec_t;

   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_issue();
      for (int k = 0; k < 20 && !issue_valid; k++) step();
      check("issue_wait", {31'd0, issue_valid}, 32'd1);
   endtask

   task automatic check_fields(input int i);
      check($sformatf("v%0d_opcode", i), {28'd0, opcode}, {28'd0, tbl[i].op});
      check($sformatf("v%0d_addr1", i), {27'd0, addr1}, {27'd0, tbl[i].a1});
      check($sformatf("v%0d_addr2", i), {27'd0, addr2}, {27'd0, tbl[i].a2});
      check($sformatf("v%0d_addr3", i), {27'd0, addr3}, {27'd0, tbl[i].a3});
      check($sformatf("v%0d_load_number", i), {24'd0, load_number}, {24'd0, tbl[i].ln});
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #2 rst_n = 1'b1;
   endtask

   initial begin
      tbl[0] = '{8'h00, 32'h119D2055, 4'h1, 5'd3, 5'd7, 5'd9, 8'h55, 8'h01};
      tbl[1] = '{8'h01, {4'h2, 5'd31, 5'd0, 5'd17, 5'd0, 8'hA7}, 4'h2, 5'd31, 5'd0, 5'd17, 8'hA7, 8'h02};
      tbl[2] = '{8'h40, {4'h3, 5'd1, 5'd2, 5'd4, 5'd0, 8'h80}, 4'h3, 5'd1, 5'd2, 5'd4, 8'h80, 8'h41};
      tbl[3] = '{8'h41, {4'h0, 5'd8, 5'd16, 5'd30, 5'h1F, 8'h00}, 4'h0, 5'd8, 5'd16, 5'd30, 8'h00, 8'h42};
      tbl[4] = '{8'hFF, {4'hD, 5'd21, 5'd10, 5'd5, 5'd3, 8'hFF}, 4'hD, 5'd21, 5'd10, 5'd5, 8'hFF, 8'h00};

      for (int a = 0; a < 256; a++) mem[a] = 32'hF000_0000;
      for (int i = 0; i < 5; i++) mem[tbl[i].addr] = tbl[i].word;
      mem[8'h02] = 32'hE000_0040;
      mem[8'h42] = 32'hE000_00FF;

      // reset state
      #12;
      check("rst_imem_en", {31'd0, imem_en}, 32'd0);
      check("rst_issue_valid", {31'd0, issue_valid}, 32'd0);
      check("rst_pc", {24'd0, pc}, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_fields", {opcode, addr1, addr2, addr3, load_number}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      step();

      // start latency
      start = 1'b1;
      step();
      start = 1'b0;
      check("lat_c1_imem_en", {31'd0, imem_en}, 32'd1);
      check("lat_c1_imem_addr", {24'd0, imem_addr}, 32'd0);
      step();
      check("lat_c2_imem_en", {31'd0, imem_en}, 32'd0);
      step();
      check("lat_c3_issue_valid", {31'd0, issue_valid}, 32'd0);
      step();
      check("lat_c4_issue_valid", {31'd0, issue_valid}, 32'd1);

      // table loop: issue order through jump and wrap-around
      for (int i = 0; i < 5; i++) begin
         wait_issue();
         check_fields(i);
         check($sformatf("v%0d_pc", i), {24'd0, pc}, {24'd0, tbl[i].pc_exp});
         check($sformatf("v%0d_fetch_addr", i), {24'd0, last_fetch}, {24'd0, tbl[i].addr});
         if (i == 0) begin
            for (int c = 0; c < 10; c++) begin
               start = (c == 3);
               step();
               check("stall_issue_valid", {31'd0, issue_valid}, 32'd1);
               check_fields(0);
               check("stall_pc", {24'd0, pc}, 32'd1);
            end
            start = 1'b0;
         end
         ex_ready = 1'b1;
         step();
         ex_ready = 1'b0;
         check($sformatf("v%0d_done_issue_valid", i), {31'd0, issue_valid}, 32'd0);
         check($sformatf("v%0d_next_imem_en", i), {31'd0, imem_en}, 32'd1);
         check($sformatf("v%0d_next_imem_addr", i), {24'd0, imem_addr}, {24'd0, tbl[i].pc_exp});
      end
      check("ctrl_never_issued", ctrl_issued, 0);

      // halt and restart
      pulse_reset();
      for (int a = 0; a < 5; a++) mem[a] = {4'h5, 5'(a), 5'(a + 1), 5'(a + 2), 5'd0, 8'(a)};
      mem[5] = 32'hF000_0000;
      mem[6] = 32'h7000_0000;
      step();
      ex_ready = 1'b1;
      begin
         int base;
         base = issues;
         start = 1'b1;
         step();
         start = 1'b0;
         for (int k = 0; k < 60 && !halted; k++) step();
         check("halt_reached", {31'd0, halted}, 32'd1);
         check("halt_pc", {24'd0, pc}, 32'd6);
         check("halt_issues", issues - base, 5);
      end
`ifdef IFD_INSTR_COUNT_EN
      check("halt_instr_count", {16'd0, instr_count}, 32'd5);
`endif
      for (int c = 0; c < 20; c++) begin
         step();
         check("halt_hold", {halted, imem_en, issue_valid, pc}, {1'b1, 1'b0, 1'b0, 8'd6});
      end
      start = 1'b1;
      step();
      start = 1'b0;
      check("restart_halted", {31'd0, halted}, 32'd0);
      check("restart_imem_en", {31'd0, imem_en}, 32'd1);
      check("restart_imem_addr", {24'd0, imem_addr}, 32'd0);
`ifdef IFD_INSTR_COUNT_EN
      check("restart_instr_count", {16'd0, instr_count}, 32'd0);
`endif

      // mid-issue asynchronous reset
      for (int c = 0; c < 10; c++) step();
      ex_ready = 1'b0;
      wait_issue();
      step();
      step();
      check("pre_rst_issue_valid", {31'd0, issue_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_issue_valid", {31'd0, issue_valid}, 32'd0);
      check("async_rst_pc", {24'd0, pc}, 32'd0);
      check("async_rst_fields", {opcode, addr1, addr2, addr3, load_number}, 32'd0);
`ifdef IFD_INSTR_COUNT_EN
      check("async_rst_instr_count", {16'd0, instr_count}, 32'd0);
`endif
      #10 rst_n = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
